// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: decodes every RV32I/RV64I immediate
// format, sign- or zero-extends it to XLEN and presents it behind a
// valid/ready register with a one-entry skid so hazard stalls and flushes
// never lose or duplicate an immediate.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      instr,
    input  logic [2:0]       imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_ext,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    // instr[k] holds instruction bit k+7, so I[n] below is instr[n-7].
    logic            sgn;
    logic            sext_fmt;
    logic [31:0]     imm32;
    logic [XLEN-1:0] dec_imm;
    logic            dec_err;

    assign sgn = instr[24];

    // Format decode: build the low 32 bits, then fill the upper bits with the
    // sign for signed formats and with zero for SHAMT/ZIMM.
    always_comb begin
        imm32    = '0;
        sext_fmt = 1'b0;
        dec_err  = 1'b0;
        case (imm_src)
            3'b000: begin
                imm32    = {{20{sgn}}, instr[24:13]};
                sext_fmt = 1'b1;
            end
            3'b001: begin
                imm32    = {{20{sgn}}, instr[24:18], instr[4:0]};
                sext_fmt = 1'b1;
            end
            3'b010: begin
                imm32    = {{20{sgn}}, instr[0], instr[23:18], instr[4:1], 1'b0};
                sext_fmt = 1'b1;
            end
            3'b011: begin
                imm32    = {{12{sgn}}, instr[12:5], instr[13], instr[23:14], 1'b0};
                sext_fmt = 1'b1;
            end
            3'b100: begin
                imm32    = {instr[24:5], 12'b0};
                sext_fmt = 1'b1;
            end
            3'b101: begin
                if (XLEN == 64) begin
                    imm32 = {26'b0, instr[18:13]};
                end else begin
                    imm32 = {27'b0, instr[17:13]};
                end
            end
            3'b110: begin
                imm32 = {27'b0, instr[12:8]};
            end
            default: begin
                dec_err = 1'b1;
            end
        endcase
        dec_imm        = {XLEN{sext_fmt & sgn}};
        dec_imm[31:0]  = imm32;
    end

    // Main output register and skid register.
    logic             main_valid_q, main_valid_d;
    logic [XLEN-1:0]  main_imm_q, main_imm_d;
    logic [TAG_W-1:0] main_tag_q, main_tag_d;
    logic             main_err_q, main_err_d;
    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             skid_err_q, skid_err_d;

    logic accept;
    logic drain;

    assign in_ready  = ~skid_valid_q;
    assign accept    = in_valid & in_ready;
    assign drain     = main_valid_q & out_ready;

    assign out_valid = main_valid_q;
    assign imm_ext   = main_imm_q;
    assign out_tag   = main_tag_q;
    assign out_err   = main_err_q;

    // Next-state: flush wins; otherwise skid refills main on drain, and a new
    // entry lands in main when it frees up or in skid when main is stalled.
    always_comb begin
        main_valid_d = main_valid_q;
        main_imm_d   = main_imm_q;
        main_tag_d   = main_tag_q;
        main_err_d   = main_err_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_tag_d   = skid_tag_q;
        skid_err_d   = skid_err_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain) begin
            if (skid_valid_q) begin
                main_imm_d   = skid_imm_q;
                main_tag_d   = skid_tag_q;
                main_err_d   = skid_err_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_imm_d   = dec_imm;
                main_tag_d   = in_tag;
                main_err_d   = dec_err;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q) begin
                main_valid_d = 1'b1;
                main_imm_d   = dec_imm;
                main_tag_d   = in_tag;
                main_err_d   = dec_err;
            end else begin
                skid_valid_d = 1'b1;
                skid_imm_d   = dec_imm;
                skid_tag_d   = in_tag;
                skid_err_d   = dec_err;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_imm_q   <= '0;
            main_tag_q   <= '0;
            main_err_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
            skid_err_q   <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_imm_q   <= main_imm_d;
            main_tag_q   <= main_tag_d;
            main_err_q   <= main_err_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_tag_q   <= skid_tag_d;
            skid_err_q   <= skid_err_d;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus;
// accepted inputs are pushed to per-instance expectation queues and an
// output monitor pops and compares on every transfer.
module tb_imm_gen_pipe;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             out_ready;
    logic [24:0]      instr;
    logic [2:0]       imm_src;
    logic [TAG_W-1:0] in_tag;

    logic             in_ready32, out_valid32, err32;
    logic [31:0]      imm32;
    logic [TAG_W-1:0] tag32;
    logic             in_ready64, out_valid64, err64;
    logic [63:0]      imm64;
    logic [TAG_W-1:0] tag64;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0]      imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready32),
        .instr     (instr),
        .imm_src   (imm_src),
        .in_tag    (in_tag),
        .out_valid (out_valid32),
        .out_ready (out_ready),
        .imm_ext   (imm32),
        .out_tag   (tag32),
        .out_err   (err32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) u_dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready64),
        .instr     (instr),
        .imm_src   (imm_src),
        .in_tag    (in_tag),
        .out_valid (out_valid64),
        .out_ready (out_ready),
        .imm_ext   (imm64),
        .out_tag   (tag64),
        .out_err   (err64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint fld(input logic [31:0] w, input int hi, input int lo);
        longint unsigned uw;
        uw = 64'(w);
        return longint'((uw >> lo) & ((64'd1 << (hi - lo + 1)) - 1));
    endfunction

    // Reference: immediate value as a plain integer, then two's complement in XLEN.
    function automatic void ref_model(input logic [31:0] w, input logic [2:0] src,
                                      input int xlen, output logic [63:0] imm,
                                      output logic err);
        longint v;
        longint neg;
        v   = 0;
        err = 1'b0;
        neg = w[31] ? 1 : 0;
        case (src)
            3'd0: v = fld(w, 31, 20) - neg * 4096;
            3'd1: v = fld(w, 31, 25) * 32 + fld(w, 11, 7) - neg * 4096;
            3'd2: v = neg * 4096 + fld(w, 7, 7) * 2048 + fld(w, 30, 25) * 32
                      + fld(w, 11, 8) * 2 - neg * 8192;
            3'd3: v = neg * (64'd1 << 20) + fld(w, 19, 12) * 4096 + fld(w, 20, 20) * 2048
                      + fld(w, 30, 21) * 2 - neg * (64'd1 << 21);
            3'd4: v = fld(w, 31, 12) * 4096 - neg * (64'd1 << 32);
            3'd5: v = (xlen == 64) ? fld(w, 25, 20) : fld(w, 24, 20);
            3'd6: v = fld(w, 19, 15);
            default: begin
                v   = 0;
                err = 1'b1;
            end
        endcase
        imm = 64'(v);
        if (xlen == 32) imm[63:32] = 32'h0;
    endfunction

    // Input side: record every accepted entry; flush or reset empties the queues.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!rst_n || flush) begin
            q32.delete();
            q64.delete();
        end else if (in_valid && in_ready32) begin
            e.tag = in_tag;
            ref_model({instr, 7'b0}, imm_src, 32, e.imm, e.err);
            q32.push_back(e);
            ref_model({instr, 7'b0}, imm_src, 64, e.imm, e.err);
            q64.push_back(e);
        end
    end

    // Output side: compare every transfer and check stall stability.
    logic        prev_hold = 1'b0;
    logic [63:0] prev_pack = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && out_valid32)
                chk("stall_stable32", 64'({imm32, tag32, err32}), prev_pack);
            if (out_valid32 && out_ready) begin
                if (q32.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb32_unexpected actual tag=%0d imm=%h expected none", tag32, imm32);
                end else begin
                    e = q32.pop_front();
                    chk("sb32_imm", 64'(imm32), e.imm);
                    chk("sb32_tag", 64'(tag32), 64'(e.tag));
                    chk("sb32_err", 64'(err32), 64'(e.err));
                end
            end
            if (out_valid64 && out_ready) begin
                if (q64.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb64_unexpected actual tag=%0d imm=%h expected none", tag64, imm64);
                end else begin
                    e = q64.pop_front();
                    chk("sb64_imm", imm64, e.imm);
                    chk("sb64_tag", 64'(tag64), 64'(e.tag));
                    chk("sb64_err", 64'(err64), 64'(e.err));
                end
            end
            prev_hold = out_valid32 && !out_ready;
            prev_pack = 64'({imm32, tag32, err32});
        end
    end

    task automatic drive(input logic [31:0] w, input logic [2:0] src, input logic [TAG_W-1:0] tag);
        instr    = w[31:7];
        imm_src  = src;
        in_tag   = tag;
        in_valid = 1'b1;
    endtask

    // Hold the beat until it is accepted; returns at posedge+1 after the accept edge.
    task automatic send(input logic [31:0] w, input logic [2:0] src, input logic [TAG_W-1:0] tag);
        int n;
        n = 0;
        drive(w, src, tag);
        while (!in_ready32 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 50) chk("send_timeout", 64'(in_ready32), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input string name, input logic [31:0] w, input logic [2:0] src,
                            input logic [TAG_W-1:0] tag, input logic [31:0] e32,
                            input logic [63:0] e64, input logic eerr);
        send(w, src, tag);
        chk({name, "_lat1"}, 64'(out_valid32), 64'd1);
        chk({name, "_imm32"}, 64'(imm32), 64'(e32));
        chk({name, "_imm64"}, imm64, e64);
        chk({name, "_err"}, 64'(err64), 64'(eerr));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        instr     = '0;
        imm_src   = '0;
        in_tag    = '0;
        #12;
        chk("rst_out_valid", 64'(out_valid32), 64'd0);
        chk("rst_in_ready", 64'(in_ready32), 64'd1);
        chk("rst_imm", imm64, 64'd0);
        chk("rst_tag", 64'(tag64), 64'd0);
        chk("rst_err", 64'(err64), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Format vectors.
        send_vec("i_type", 32'hFFF00093, 3'd0, 5'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        send_vec("b_type", 32'hFE000EE3, 3'd2, 5'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        send_vec("j_type", 32'h0080006F, 3'd3, 5'd3, 32'h00000008, 64'h8, 1'b0);
        send_vec("u_type", 32'h123450B7, 3'd4, 5'd4, 32'h12345000, 64'h12345000, 1'b0);
        send_vec("u_neg", 32'h800000B7, 3'd4, 5'd5, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
        send_vec("shamt", 32'h03F01013, 3'd5, 5'd6, 32'h0000001F, 64'h3F, 1'b0);
        send_vec("bad_src", 32'hFFFFFFFF, 3'd7, 5'd7, 32'h0, 64'h0, 1'b1);

        // Backpressure: two accepts fill main and skid, third is refused.
        out_ready = 1'b0;
        drive(32'h00100093, 3'd0, 5'd1);
        @(posedge clk);
        #1;
        drive(32'h00200093, 3'd0, 5'd2);
        @(posedge clk);
        #1;
        chk("bp_in_ready_low", 64'(in_ready32), 64'd0);
        chk("bp_tag_hold", 64'(tag32), 64'd1);
        drive(32'h00300093, 3'd0, 5'd3);
        @(posedge clk);
        #1;
        chk("bp_tag_still1", 64'(tag32), 64'd1);
        chk("bp_valid", 64'(out_valid32), 64'd1);
        out_ready = 1'b1;
        send(32'h00300093, 3'd0, 5'd3);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_drained", 64'(q32.size()), 64'd0);

        // Flush with main and skid full plus an incoming beat.
        out_ready = 1'b0;
        drive(32'h00A00093, 3'd0, 5'd10);
        @(posedge clk);
        #1;
        drive(32'h00B00093, 3'd0, 5'd11);
        @(posedge clk);
        #1;
        drive(32'h00C00093, 3'd0, 5'd12);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", 64'(out_valid32), 64'd0);
        chk("fl_in_ready", 64'(in_ready32), 64'd1);
        chk("fl_out_valid64", 64'(out_valid64), 64'd0);
        out_ready = 1'b1;
        // Flush on an accept into an empty main drops that beat too.
        drive(32'h00D00093, 3'd0, 5'd13);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_drop_accept", 64'(out_valid32), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("fl_never_appear", 64'(out_valid32), 64'd0);

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        drive(32'hFFF00093, 3'd0, 5'd20);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("ar_pre_valid", 64'(out_valid32), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid32), 64'd0);
        chk("ar_imm32", 64'(imm32), 64'd0);
        chk("ar_imm64", imm64, 64'd0);
        chk("ar_tag", 64'(tag64), 64'd0);
        chk("ar_err", 64'(err32), 64'd0);
        chk("ar_in_ready", 64'(in_ready32), 64'd1);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send_vec("post_rst", 32'h7FF00093, 3'd0, 5'd21, 32'h000007FF, 64'h7FF, 1'b0);

        // Randomized traffic with stalls and occasional flushes.
        for (int c = 0; c < 800; c++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 40) == 0;
            instr     = 25'($urandom);
            imm_src   = 3'($urandom);
            in_tag    = TAG_W'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("final_q32_empty", 64'(q32.size()), 64'd0);
        chk("final_q64_empty", 64'(q64.size()), 64'd0);
        chk("final_idle", 64'(out_valid32), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
